// File: rtl/csr_timer_intc.sv
// Timer (TID/TCFG/TVAL/TICLR) and interrupt aggregation for the LoongArch CSR file.
// Optional feature macro CSR_HWI_EDGE_LATCH_EN: edge-latched hw_int with HWICLR at 0x45.
module csr_timer_intc #(
  parameter int unsigned TIMER_W     = 32,
  parameter int unsigned N_HWI       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] CORE_ID     = 32'd0
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             csr_we,
  input  logic [13:0]      csr_waddr,
  input  logic [31:0]      csr_wdata,
  input  logic [31:0]      csr_wmask,
  input  logic [13:0]      csr_raddr,
  output logic [31:0]      csr_rdata,
  input  logic [N_HWI-1:0] hw_int,
  input  logic             ipi_in,
  input  logic [1:0]       swi,
  input  logic [12:0]      ecfg_lie,
  input  logic             crmd_ie,
  output logic [12:0]      is_out,
  output logic             timer_int,
  output logic             int_req
);

  localparam logic [13:0] AddrTid   = 14'h040;
  localparam logic [13:0] AddrTcfg  = 14'h041;
  localparam logic [13:0] AddrTval  = 14'h042;
  localparam logic [13:0] AddrTiclr = 14'h044;
`ifdef CSR_HWI_EDGE_LATCH_EN
  localparam logic [13:0] AddrHwiclr = 14'h045;
`endif

  logic [31:0]                       tid_q, tid_d;
  logic [TIMER_W-1:0]                tcfg_q, tcfg_d, tval_q, tval_d, tcfg_wval;
  logic                              armed_q, armed_d, ti_q, ti_d, int_req_q, int_req_d;
  logic [SYNC_STAGES-1:0][N_HWI-1:0] hwi_sync_q;
  logic [SYNC_STAGES-1:0]            ipi_sync_q;
  logic [N_HWI-1:0]                  hwi_level, hwi_src;
  logic [7:0]                        hwi_vec;
  logic                              tcfg_we, ticlr, fire;

  assign tcfg_we   = csr_we && (csr_waddr == AddrTcfg);
  assign tcfg_wval = (tcfg_q & ~csr_wmask[TIMER_W-1:0])
                   | (csr_wdata[TIMER_W-1:0] & csr_wmask[TIMER_W-1:0]);
  assign ticlr     = csr_we && (csr_waddr == AddrTiclr) && csr_wdata[0] && csr_wmask[0];
  assign fire      = armed_q && (tval_q == '0);

  always_comb begin
    tid_d   = tid_q;
    tcfg_d  = tcfg_q;
    tval_d  = tval_q;
    armed_d = armed_q;
    if (csr_we && (csr_waddr == AddrTid)) begin
      tid_d = (tid_q & ~csr_wmask) | (csr_wdata & csr_wmask);
    end
    if (tcfg_we) begin
      tcfg_d = tcfg_wval;
      if (tcfg_wval[0]) begin
        tval_d  = {tcfg_wval[TIMER_W-1:2], 2'b00};
        armed_d = 1'b1;
      end else begin
        armed_d = 1'b0;
      end
    end else if (armed_q) begin
      if (tval_q != '0) begin
        tval_d = tval_q - TIMER_W'(1);
      end else if (tcfg_q[1]) begin
        tval_d = {tcfg_q[TIMER_W-1:2], 2'b00};
      end else begin
        // One-shot: park at all-ones so the timer cannot fire again
        tval_d  = '1;
        armed_d = 1'b0;
      end
    end
  end

  // A fire in the same cycle as a TICLR write wins
  assign ti_d = fire ? 1'b1 : (ticlr ? 1'b0 : ti_q);

  assign hwi_level = hwi_sync_q[SYNC_STAGES-1];

`ifdef CSR_HWI_EDGE_LATCH_EN
  logic [N_HWI-1:0] hwi_prev_q, hwi_pend_q, hwi_pend_d, hwi_clr;

  assign hwi_clr    = (csr_we && (csr_waddr == AddrHwiclr)) ?
                      (csr_wdata[N_HWI-1:0] & csr_wmask[N_HWI-1:0]) : '0;
  assign hwi_pend_d = (hwi_pend_q & ~hwi_clr) | (hwi_level & ~hwi_prev_q);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      hwi_prev_q <= '0;
      hwi_pend_q <= '0;
    end else begin
      hwi_prev_q <= hwi_level;
      hwi_pend_q <= hwi_pend_d;
    end
  end

  assign hwi_src = hwi_pend_q;
`else
  assign hwi_src = hwi_level;
`endif

  always_comb begin
    hwi_vec              = '0;
    hwi_vec[N_HWI-1:0]   = hwi_src;
  end

  assign is_out    = {ipi_sync_q[SYNC_STAGES-1], ti_q, 1'b0, hwi_vec, swi};
  assign int_req_d = crmd_ie & (|(is_out & ecfg_lie));
  assign timer_int = ti_q;
  assign int_req   = int_req_q;

  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      AddrTid:  csr_rdata = tid_q;
      AddrTcfg: csr_rdata = 32'(tcfg_q);
      AddrTval: csr_rdata = 32'(tval_q);
      default:  csr_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      tid_q      <= CORE_ID;
      tcfg_q     <= '0;
      tval_q     <= '0;
      armed_q    <= 1'b0;
      ti_q       <= 1'b0;
      int_req_q  <= 1'b0;
      hwi_sync_q <= '0;
      ipi_sync_q <= '0;
    end else begin
      tid_q      <= tid_d;
      tcfg_q     <= tcfg_d;
      tval_q     <= tval_d;
      armed_q    <= armed_d;
      ti_q       <= ti_d;
      int_req_q  <= int_req_d;
      hwi_sync_q <= {hwi_sync_q[SYNC_STAGES-2:0], hw_int};
      ipi_sync_q <= {ipi_sync_q[SYNC_STAGES-2:0], ipi_in};
    end
  end

endmodule

// File: tb/tb_csr_timer_intc.sv
// Randomised and directed bench for csr_timer_intc against a behavioural CSR/timer model.
// Honours CSR_HWI_EDGE_LATCH_EN when defined.
module tb_csr_timer_intc;
  localparam int unsigned TW  = 32;
  localparam int unsigned NH  = 8;
  localparam int unsigned SS  = 2;
  localparam logic [31:0] CID = 32'h0000_0003;

  logic          clk = 1'b0;
  logic          areset;
  logic          csr_we;
  logic [13:0]   csr_waddr, csr_raddr;
  logic [31:0]   csr_wdata, csr_wmask, csr_rdata;
  logic [NH-1:0] hw_int;
  logic          ipi_in, crmd_ie, timer_int, int_req;
  logic [1:0]    swi;
  logic [12:0]   ecfg_lie, is_out;

  csr_timer_intc #(.TIMER_W(TW), .N_HWI(NH), .SYNC_STAGES(SS), .CORE_ID(CID)) dut (
    .clk(clk), .areset(areset), .csr_we(csr_we), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .csr_wmask(csr_wmask), .csr_raddr(csr_raddr),
    .csr_rdata(csr_rdata), .hw_int(hw_int), .ipi_in(ipi_in), .swi(swi),
    .ecfg_lie(ecfg_lie), .crmd_ie(crmd_ie), .is_out(is_out), .timer_int(timer_int),
    .int_req(int_req)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  // Behavioural model state
  logic [31:0]   m_tid, m_tcfg, m_tval;
  bit            m_armed, m_ti, m_int_req;
  logic [NH-1:0] m_hw [SS+1];  // input history, [0] = most recent sample
  bit            m_ipi [SS];
`ifdef CSR_HWI_EDGE_LATCH_EN
  logic [NH-1:0] m_pend;
`endif

  function automatic logic [12:0] m_is_out();
    logic [7:0] h;
    h = '0;
`ifdef CSR_HWI_EDGE_LATCH_EN
    h[NH-1:0] = m_pend;
`else
    h[NH-1:0] = m_hw[SS-1];
`endif
    return {m_ipi[SS-1], m_ti, 1'b0, h, swi};
  endfunction

  function automatic logic [31:0] m_read(input logic [13:0] a);
    case (a)
      14'h040: return m_tid;
      14'h041: return m_tcfg;
      14'h042: return m_tval;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old);
    return (old & ~csr_wmask) | (csr_wdata & csr_wmask);
  endfunction

  task automatic model_reset();
    m_tid = CID; m_tcfg = 0; m_tval = 0; m_armed = 0; m_ti = 0; m_int_req = 0;
    for (int i = 0; i <= SS; i++) m_hw[i] = '0;
    for (int i = 0; i < SS; i++) m_ipi[i] = 0;
`ifdef CSR_HWI_EDGE_LATCH_EN
    m_pend = '0;
`endif
  endtask

  task automatic model_step();
    logic [12:0] is_now;
    logic [31:0] eff;
    bit fire;
    is_now = m_is_out();
    eff    = csr_wdata & csr_wmask;
    fire   = m_armed && (m_tval == 0);
    if (csr_we && csr_waddr == 14'h040) m_tid = merge(m_tid);
    if (csr_we && csr_waddr == 14'h041) begin
      m_tcfg = merge(m_tcfg);
      m_armed = m_tcfg[0];
      if (m_tcfg[0]) m_tval = m_tcfg & ~32'h3;
    end else if (m_armed) begin
      if (m_tval != 0) m_tval = m_tval - 1;
      else if (m_tcfg[1]) m_tval = m_tcfg & ~32'h3;
      else begin m_tval = 32'hFFFF_FFFF; m_armed = 0; end
    end
    if (fire) m_ti = 1;
    else if (csr_we && csr_waddr == 14'h044 && eff[0]) m_ti = 0;
`ifdef CSR_HWI_EDGE_LATCH_EN
    if (csr_we && csr_waddr == 14'h045) m_pend = m_pend & ~eff[NH-1:0];
    m_pend = m_pend | (m_hw[SS-1] & ~m_hw[SS]);
`endif
    for (int i = SS; i > 0; i--) m_hw[i] = m_hw[i-1];
    m_hw[0] = hw_int;
    for (int i = SS - 1; i > 0; i--) m_ipi[i] = m_ipi[i-1];
    m_ipi[0] = ipi_in;
    m_int_req = crmd_ie && ((is_now & ecfg_lie) != 0);
  endtask

  task automatic compare_all();
    check("is_out", 32'(is_out), 32'(m_is_out()));
    check("timer_int", 32'(timer_int), 32'(m_ti));
    check("int_req", 32'(int_req), 32'(m_int_req));
    check("rdata", csr_rdata, m_read(csr_raddr));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!areset) model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic csr_write(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
    csr_we = 1'b1; csr_waddr = a; csr_wdata = d; csr_wmask = m;
    tick();
    csr_we = 1'b0;
  endtask

  function automatic logic [13:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return 14'h040;
      1: return 14'h041;
      2: return 14'h042;
      3: return 14'h044;
      4: return 14'h045;
      default: return 14'($urandom);
    endcase
  endfunction

  int  n;
  bit  seen;

  initial begin
    areset = 1'b1; csr_we = 0; csr_waddr = 0; csr_wdata = 0; csr_wmask = 0;
    csr_raddr = 14'h040; hw_int = '0; ipi_in = 0; swi = 2'b10; ecfg_lie = '0; crmd_ie = 0;
    model_reset();
    @(posedge clk); #1;
    check("rst_is_out", 32'(is_out), 32'h002);
    check("rst_tid", csr_rdata, CID);
    compare_all();
    idle(1);
    areset = 1'b0;
    swi = 2'b00;

    // Periodic timer: InitVal=4 -> tval 16
    crmd_ie = 1; ecfg_lie = 13'h800; csr_raddr = 14'h042;
    csr_write(14'h041, 32'h13, 32'hFFFF_FFFF);
    check("per_tval_load", csr_rdata, 32'd16);
    n = 0;
    while (!timer_int && n < 40) begin tick(); n++; end
    check("per_ti_latency", n, 17);
    check("per_tval_reload", csr_rdata, 32'd16);
    check("per_int_req_lag", 32'(int_req), 0);
    tick();
    check("per_int_req", 32'(int_req), 1);
    csr_write(14'h044, 32'h1, 32'hFFFF_FFFF);
    check("per_ti_cleared", 32'(timer_int), 0);
    tick();
    check("per_int_req_drop", 32'(int_req), 0);

    // One-shot: InitVal=2 -> tval 8
    csr_write(14'h041, 32'h9, 32'hFFFF_FFFF);
    n = 0;
    while (!timer_int && n < 40) begin tick(); n++; end
    check("os_ti_latency", n, 9);
    check("os_tval_parked", csr_rdata, 32'hFFFF_FFFF);
    idle(5);
    check("os_tval_hold", csr_rdata, 32'hFFFF_FFFF);
    csr_write(14'h044, 32'h1, 32'hFFFF_FFFF);
    seen = 0;
    for (int i = 0; i < 100; i++) begin tick(); if (timer_int) seen = 1; end
    check("os_quiet", 32'(seen), 0);

    // TICLR coincident with a fire: set wins
    csr_write(14'h041, 32'h7, 32'hFFFF_FFFF);
    idle(4);
    check("sim_tval_zero", csr_rdata, 32'd0);
    csr_write(14'h044, 32'h1, 32'hFFFF_FFFF);
    check("sim_set_wins", 32'(timer_int), 1);
    csr_raddr = 14'h041;
    csr_write(14'h041, 32'h0, 32'h1);
    check("tcfg_masked", csr_rdata, 32'h6);
    csr_write(14'h044, 32'h1, 32'h1);
    check("sim_ti_clr", 32'(timer_int), 0);

    // Hardware interrupt line 3 -> IS[5]
    ecfg_lie = 13'h020; crmd_ie = 1; hw_int = 8'h08;
    n = 0;
    while (!is_out[5] && n < 20) begin tick(); n++; end
`ifdef CSR_HWI_EDGE_LATCH_EN
    check("hwi_latency", n, SS + 1);
`else
    check("hwi_latency", n, SS);
`endif
    check("hwi_int_req_lag", 32'(int_req), 0);
    tick();
    check("hwi_int_req", 32'(int_req), 1);
    crmd_ie = 0;
    idle(2);
    check("hwi_ie_off", 32'(int_req), 0);
    check("hwi_is_held", 32'(is_out[5]), 1);
    hw_int = '0;
    idle(4);
    csr_write(14'h045, 32'hFF, 32'hFFFF_FFFF);
    idle(2);
    check("hwi_released", 32'(is_out[5]), 0);

    // 0x45 reads as 0; with the edge latch, a 1-cycle pulse sticks until cleared
    csr_raddr = 14'h045; #1;
    check("hwiclr_read", csr_rdata, 0);
    hw_int = 8'h01;
    tick();
    hw_int = 8'h00;
    idle(5);
`ifdef CSR_HWI_EDGE_LATCH_EN
    check("edge_sticky", 32'(is_out[2]), 1);
    csr_write(14'h045, 32'h1, 32'hFFFF_FFFF);
    check("edge_cleared", 32'(is_out[2]), 0);
`else
    check("level_pulse_gone", 32'(is_out[2]), 0);
`endif

    // Random phase
    for (int c = 0; c < 3000; c++) begin
      csr_we    = ($urandom_range(0, 3) == 0);
      csr_waddr = pick_addr();
      csr_wdata = (csr_waddr == 14'h041) ? ($urandom & 32'h3F) : $urandom;
      csr_wmask = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom;
      csr_raddr = pick_addr();
      if ($urandom_range(0, 15) == 0) hw_int = NH'($urandom);
      if ($urandom_range(0, 15) == 0) ipi_in = ~ipi_in;
      swi = 2'($urandom);
      if ($urandom_range(0, 49) == 0) ecfg_lie = 13'($urandom);
      if ($urandom_range(0, 19) == 0) crmd_ie = ~crmd_ie;
      if ($urandom_range(0, 499) == 0) begin
        areset = 1'b1; #1;
        model_reset();
        compare_all();
        tick();
        areset = 1'b0;
      end
      tick();
    end
    csr_we = 0; hw_int = '0; ipi_in = 0;

    // Reset mid-count
    csr_raddr = 14'h042;
    csr_write(14'h041, 32'h11, 32'hFFFF_FFFF);
    n = 0;
    while (csr_rdata != 32'd7 && n < 40) begin tick(); n++; end
    check("mid_reach7", csr_rdata, 32'd7);
    areset = 1'b1; #1;
    model_reset();
    check("mid_tval", csr_rdata, 0);
    check("mid_ti", 32'(timer_int), 0);
    check("mid_int_req", 32'(int_req), 0);
    tick();
    areset = 1'b0;
    idle(5);
    check("mid_tval_stays", csr_rdata, 0);
    csr_raddr = 14'h040; #1;
    check("mid_tid", csr_rdata, CID);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
